// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: access sizes, FSM states,
// and helpers that turn an access size into a beat count and an alignment verdict.
// No ports; imported by the interface, sequencer and top.
package ram_port_arbiter_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEAT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Number of byte beats for an access size; 0 marks an illegal size.
   function automatic logic [2:0] beat_count(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         SIZE_WORD: return 3'd4;
         default:   return 3'd0;
      endcase
   endfunction

   // Natural alignment check on the low address bits.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SIZE_WORD: return (addr_lo == 2'b00);
         SIZE_HALF: return (addr_lo[0] == 1'b0);
         default:   return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the fetch port, data port and byte-RAM port around the arbiter.
// master: pipeline/RAM side (drives requests and ram_rdata); slave: the arbiter.
// Request/response is req-held-until-rdy; the RAM port is a combinational-read byte array.
interface ram_port_arbiter_if #(
   parameter int RAM_AW = 8
);
   // instruction fetch port
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_rdy;
   logic [31:0]       if_rdata;
   // data memory port
   logic              dm_req;
   logic              dm_we;
   logic [1:0]        dm_size;
   logic [31:0]       dm_addr;
   logic [31:0]       dm_wdata;
   logic              dm_rdy;
   logic              dm_err;
   logic [31:0]       dm_rdata;
   // byte RAM port
   logic [RAM_AW-1:0] ram_addr;
   logic              ram_we;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata;

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, ram_rdata,
      input  if_rdy, if_rdata, dm_rdy, dm_err, dm_rdata, ram_addr, ram_we, ram_wdata
   );

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, ram_rdata,
      output if_rdy, if_rdata, dm_rdy, dm_err, dm_rdata, ram_addr, ram_we, ram_wdata
   );

endinterface

// File: rtl/ram_port_arbiter_sequencer.sv
// Byte-beat sequencer: walks n consecutive RAM bytes big-endian, splitting write words and assembling read words.
// Latency: n beats after start; last is high during the final beat, rd_word is valid with it.
// Backpressure: none; once started it runs to completion (only reset aborts it).
// Ports: start/start_* (launch an access), ram_* (byte RAM), last/rd_word (completion + assembled read data).
module ram_byte_sequencer #(
   parameter int RAM_AW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [RAM_AW-1:0] start_addr,
   input  logic [2:0]        start_n,
   input  logic              start_we,
   input  logic [31:0]       start_wdata,
   input  logic [7:0]        ram_rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   output logic              last,
   output logic [31:0]       rd_word
);

   logic        active;
   logic [2:0]  cnt;
   logic [2:0]  n_q;
   logic [31:0] wdata_q;
   logic [23:0] asm_q;
   logic [2:0]  first_idx;
   logic [2:0]  next_idx;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [2:0] idx);
      case (idx)
         3'd0:    return w[7:0];
         3'd1:    return w[15:8];
         3'd2:    return w[23:16];
         3'd3:    return w[31:24];
         default: return 8'h00;
      endcase
   endfunction

   // Beat i of an n-byte unit carries byte index n-1-i, so beat 0 is the MSByte.
   assign first_idx = start_n - 3'd1;
   assign next_idx  = n_q - cnt - 3'd2;

   assign last    = active && (cnt == n_q - 3'd1);
   // Earlier beats sit above the byte on the bus this cycle; asm_q starts at 0 so short reads are zero-extended.
   assign rd_word = {asm_q, ram_rdata};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active    <= 1'b0;
         cnt       <= 3'd0;
         n_q       <= 3'd0;
         wdata_q   <= 32'h0;
         asm_q     <= 24'h0;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= 8'h00;
      end else if (start) begin
         active    <= 1'b1;
         cnt       <= 3'd0;
         n_q       <= start_n;
         wdata_q   <= start_wdata;
         asm_q     <= 24'h0;
         ram_addr  <= start_addr;
         ram_we    <= start_we;
         ram_wdata <= start_we ? byte_sel(start_wdata, first_idx) : 8'h00;
      end else if (active) begin
         asm_q <= rd_word[23:0];
         if (last) begin
            active    <= 1'b0;
            ram_we    <= 1'b0;
            ram_wdata <= 8'h00;
         end else begin
            cnt       <= cnt + 3'd1;
            // address arithmetic wraps naturally at 2**RAM_AW
            ram_addr  <= ram_addr + {{(RAM_AW-1){1'b0}}, 1'b1};
            ram_wdata <= ram_we ? byte_sel(wdata_q, next_idx) : 8'h00;
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port byte RAM between instruction fetch (word reads) and data memory (byte/half/word R/W).
// Latency from the granting edge: word rdy after 5 cycles, half 3, byte 2, error 1; one idle cycle follows each response.
// Backpressure: requesters hold req until their one-cycle rdy pulse; the losing requester simply waits.
// Ports: clk, rst_n (async active-low), bus (slave side of ram_port_arbiter_if: if_*, dm_*, ram_*).
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int RAM_AW      = 8,
   parameter bit DM_PRIORITY = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   ram_port_arbiter_if.slave bus
);

   state_t      state;
   logic        owner_dm;
   logic        dm_we_q;
   logic        prefer_dm;
   logic        if_rdy_q;
   logic        dm_rdy_q;
   logic        dm_err_q;
   logic [31:0] if_rdata_q;
   logic [31:0] dm_rdata_q;

   logic        grant_if;
   logic        grant_dm;
   logic [2:0]  dm_n;
   logic        dm_legal;
   logic        seq_start;
   logic [RAM_AW-1:0] seq_addr;
   logic [2:0]  seq_n;
   logic        seq_last;
   logic [31:0] seq_rd_word;

   logic        unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr[31:RAM_AW], bus.if_addr[1:0], bus.dm_addr[31:RAM_AW]};

   always_comb begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if (state == IDLE) begin
         if (bus.if_req && bus.dm_req) begin
            grant_dm = prefer_dm;
            grant_if = !prefer_dm;
         end else begin
            grant_dm = bus.dm_req;
            grant_if = bus.if_req;
         end
      end
   end

   assign dm_n      = beat_count(bus.dm_size);
   assign dm_legal  = (dm_n != 3'd0) && is_aligned(bus.dm_size, bus.dm_addr[1:0]);
   // Bad DM requests are answered with an error and never touch the RAM.
   assign seq_start = grant_if || (grant_dm && dm_legal);
   // Fetch misalignment is dropped rather than reported.
   assign seq_addr  = grant_dm ? bus.dm_addr[RAM_AW-1:0] : {bus.if_addr[RAM_AW-1:2], 2'b00};
   assign seq_n     = grant_dm ? dm_n : 3'd4;

   ram_byte_sequencer #(.RAM_AW(RAM_AW)) u_seq (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (seq_start),
      .start_addr  (seq_addr),
      .start_n     (seq_n),
      .start_we    (grant_dm && bus.dm_we),
      .start_wdata (bus.dm_wdata),
      .ram_rdata   (bus.ram_rdata),
      .ram_addr    (bus.ram_addr),
      .ram_we      (bus.ram_we),
      .ram_wdata   (bus.ram_wdata),
      .last        (seq_last),
      .rd_word     (seq_rd_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner_dm   <= 1'b0;
         dm_we_q    <= 1'b0;
         prefer_dm  <= 1'b0;
         if_rdy_q   <= 1'b0;
         dm_rdy_q   <= 1'b0;
         dm_err_q   <= 1'b0;
         if_rdata_q <= 32'h0;
         dm_rdata_q <= 32'h0;
      end else begin
         if_rdy_q <= 1'b0;
         dm_rdy_q <= 1'b0;
         dm_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_if || grant_dm) begin
                  owner_dm <= grant_dm;
                  dm_we_q  <= bus.dm_we;
                  // DM_PRIORITY=1 tracks the last grant of any kind, so DM wins
                  // a tie right after fetch; otherwise only ties flip the pointer.
                  if (DM_PRIORITY)
                     prefer_dm <= grant_if;
                  else if (bus.if_req && bus.dm_req)
                     prefer_dm <= !prefer_dm;
                  if (grant_dm && !dm_legal) begin
                     state    <= RESP;
                     dm_rdy_q <= 1'b1;
                     dm_err_q <= 1'b1;
                  end else begin
                     state <= BEAT;
                  end
               end
            end
            BEAT: begin
               if (seq_last) begin
                  state <= RESP;
                  if (owner_dm) begin
                     dm_rdy_q <= 1'b1;
                     if (!dm_we_q)
                        dm_rdata_q <= seq_rd_word;
                  end else begin
                     if_rdy_q   <= 1'b1;
                     if_rdata_q <= seq_rd_word;
                  end
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.if_rdy   = if_rdy_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.dm_rdy   = dm_rdy_q;
   assign bus.dm_err   = dm_err_q;
   assign bus.dm_rdata = dm_rdata_q;

endmodule
